serial_pattern_tx: RTL

- Serial bit-stream transmitter that generates the single-bit `in` stimulus consumed by the week-12 Moore-machine detector.
- Captures a WIDTH-bit pattern on a start pulse and shifts it out MSB-first, one bit per DIV clock cycles.
- Supports continuous repeat mode and reports progress through busy, bit_valid, bit_idx and a one-cycle done pulse.
- Sits beside the detector in the lab top level; its bit_out drives the detector input on the FPGA or in simulation.

---
 rtl/serial_pattern_tx_if.sv | 26 ++
 rtl/serial_pattern_tx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle between a pattern source and serial_pattern_tx.
// The repeat control is named repeat_mode because 'repeat' is a reserved word.
interface serial_pattern_tx_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IdxW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] data;
  logic             repeat_mode;
  logic             bit_out;
  logic             bit_valid;
  logic [IdxW-1:0]  bit_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, data, repeat_mode,
    input  bit_out, bit_valid, bit_idx, busy, done
  );

  modport slave (
    input  start, data, repeat_mode,
    output bit_out, bit_valid, bit_idx, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a WIDTH-bit pattern on start and sends it MSB-first,
// each bit held DIV cycles, optionally repeating the saved pattern with no gap.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic                clock,
  input  logic                reset,
  serial_pattern_tx_if.slave  bus_io
);
  localparam int unsigned CntW = $clog2(DIV + 1);
  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxTop  = IdxW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  div_q, div_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             bit_out_q, bit_out_d;
  logic             done_q, done_d;

  logic accept;
  logic bit_end;
  logic frame_end;

  assign accept    = (state_q == StIdle) && bus_io.start;
  assign bit_end   = (state_q == StShift) && (div_q == DivLast);
  assign frame_end = bit_end && (idx_q == '0);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (frame_end && !bus_io.repeat_mode) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    saved_d   = saved_q;
    shift_d   = shift_q;
    div_d     = div_q;
    idx_d     = idx_q;
    bit_out_d = bit_out_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          saved_d   = bus_io.data;
          shift_d   = bus_io.data;
          bit_out_d = bus_io.data[WIDTH-1];
          idx_d     = IdxTop;
          div_d     = '0;
        end
      end
      StShift: begin
        if (bit_end) begin
          div_d = '0;
          if (idx_q == '0) begin
            done_d = 1'b1;
            // Repeat replays the saved pattern; live data is deliberately not re-sampled.
            if (bus_io.repeat_mode) begin
              shift_d   = saved_q;
              bit_out_d = saved_q[WIDTH-1];
              idx_d     = IdxTop;
            end else begin
              bit_out_d = 1'b0;
              idx_d     = '0;
            end
          end else begin
            shift_d   = shift_q << 1;
            bit_out_d = shift_q[WIDTH-2];
            idx_d     = idx_q - IdxW'(1);
          end
        end else begin
          div_d = div_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saved_q   <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      bit_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      saved_q   <= saved_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      bit_out_q <= bit_out_d;
      done_q    <= done_d;
    end
  end

  assign bus_io.bit_out   = bit_out_q;
  assign bus_io.bit_valid = (state_q == StShift);
  assign bus_io.busy      = (state_q == StShift);
  assign bus_io.bit_idx   = idx_q;
  assign bus_io.done      = done_q;
endmodule
